// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave bridging single-beat reads/writes onto a narrow BRAM port.
// One access in flight; BRAM read data arrives one cycle after an enabled read.
module axi_lite_bram_ctrl #(
    parameter int unsigned ADDR_BITW = 32,
    parameter int unsigned DATA_BITW = 32,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    input  logic [ADDR_BITW-1:0]   AwAddr_DI,
    input  logic                   AwValid_SI,
    output logic                   AwReady_SO,
    input  logic [DATA_BITW-1:0]   WData_DI,
    input  logic [DATA_BITW/8-1:0] WStrb_DI,
    input  logic                   WValid_SI,
    output logic                   WReady_SO,
    output logic [1:0]             BResp_DO,
    output logic                   BValid_SO,
    input  logic                   BReady_SI,
    input  logic [ADDR_BITW-1:0]   ArAddr_DI,
    input  logic                   ArValid_SI,
    output logic                   ArReady_SO,
    output logic [DATA_BITW-1:0]   RData_DO,
    output logic [1:0]             RResp_DO,
    output logic                   RValid_SO,
    input  logic                   RReady_SI,
    output logic                   BramClk_CO,
    output logic                   BramRst_RO,
    output logic                   BramEn_SO,
    output logic [DATA_BITW/8-1:0] BramWrEn_SO,
    output logic [ADDR_BITW-1:0]   BramAddr_SO,
    output logic [DATA_BITW-1:0]   BramWr_DO,
    input  logic [DATA_BITW-1:0]   BramRd_DI
);

    localparam int unsigned STRB_BITW = DATA_BITW / 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_RESP  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_CAPT  = 3'd4;
    localparam logic [2:0] ST_RD_RESP  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_BITW-1:0] ALIGN_MASK = ~ADDR_BITW'(STRB_BITW - 1);
    localparam logic [ADDR_BITW:0]   MEM_LIMIT  = (ADDR_BITW + 1)'(MEM_BYTES);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_aw_full;
    logic [ADDR_BITW-1:0] r_aw_addr;
    logic                 r_w_full;
    logic [DATA_BITW-1:0] r_w_data;
    logic [STRB_BITW-1:0] r_w_strb;
    logic [ADDR_BITW-1:0] r_ar_addr;
    logic                 r_wr_prio;
    logic [DATA_BITW-1:0] r_rdata;

    logic w_idle;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_cmpl;
    logic w_wr_in_range;
    logic w_rd_in_range;

    assign BramClk_CO = Clk_CI;
    assign BramRst_RO = Rst_RI;

    assign w_idle        = (r_state == ST_IDLE) && !Rst_RI;
    assign AwReady_SO    = w_idle && !r_aw_full;
    assign WReady_SO     = w_idle && !r_w_full;
    assign w_aw_hs       = AwValid_SI && AwReady_SO;
    assign w_w_hs        = WValid_SI && WReady_SO;
    // A write counts as complete if each half is buffered or arrives this cycle.
    assign w_wr_cmpl     = w_idle && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign ArReady_SO    = w_idle && !(w_wr_cmpl && r_wr_prio);
    assign w_ar_hs       = ArValid_SI && ArReady_SO;
    assign w_wr_in_range = {1'b0, r_aw_addr} < MEM_LIMIT;
    assign w_rd_in_range = {1'b0, r_ar_addr} < MEM_LIMIT;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_RD_ISSUE;
                end else if (w_wr_cmpl) begin
                    w_state_nxt = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: w_state_nxt = ST_WR_RESP;
            ST_WR_RESP:  if (BReady_SI) w_state_nxt = ST_IDLE;
            ST_RD_ISSUE: w_state_nxt = ST_RD_CAPT;
            ST_RD_CAPT:  w_state_nxt = ST_RD_RESP;
            ST_RD_RESP:  if (RReady_SI) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state   <= ST_IDLE;
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_ar_addr <= '0;
            r_wr_prio <= 1'b1;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= AwAddr_DI;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= WData_DI;
                r_w_strb <= WStrb_DI;
            end
            if (w_ar_hs) begin
                r_ar_addr <= ArAddr_DI;
            end
            if (r_state == ST_WR_ISSUE) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            // Flip only on a genuine write/read collision so conflicts alternate.
            if (w_wr_cmpl && ArValid_SI) begin
                r_wr_prio <= ~r_wr_prio;
            end
            if (r_state == ST_RD_CAPT) begin
                r_rdata <= w_rd_in_range ? BramRd_DI : '0;
            end
        end
    end

    always_comb begin
        BramEn_SO   = 1'b0;
        BramWrEn_SO = '0;
        BramAddr_SO = '0;
        BramWr_DO   = '0;
        BValid_SO   = 1'b0;
        BResp_DO    = RESP_OKAY;
        RValid_SO   = 1'b0;
        RResp_DO    = RESP_OKAY;
        RData_DO    = '0;
        if (!Rst_RI) begin
            case (r_state)
                ST_WR_ISSUE: begin
                    if (w_wr_in_range) begin
                        BramEn_SO   = 1'b1;
                        BramWrEn_SO = r_w_strb;
                        BramAddr_SO = r_aw_addr & ALIGN_MASK;
                        BramWr_DO   = r_w_data;
                    end
                end
                ST_WR_RESP: begin
                    BValid_SO = 1'b1;
                    BResp_DO  = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end
                ST_RD_ISSUE: begin
                    if (w_rd_in_range) begin
                        BramEn_SO   = 1'b1;
                        BramAddr_SO = r_ar_addr & ALIGN_MASK;
                    end
                end
                ST_RD_RESP: begin
                    RValid_SO = 1'b1;
                    RResp_DO  = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    RData_DO  = r_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_bram_ctrl.md
Name: axi_lite_bram_ctrl

Overview:
- AXI4-Lite slave that turns single-beat register-style reads and writes into narrow BRAM port accesses.
- Its BRAM-side outputs drive the master side of the data width converter, which then maps them onto the wide slave BRAM.
- Serialises reads and writes: one access in flight at a time. BRAM read latency is exactly 1 cycle.

Parameters:
- ADDR_BITW, 32, width of AXI and BRAM byte addresses.
- DATA_BITW, 32, AXI and BRAM data width; must be a power of two, at least 8. Strobe width is DATA_BITW/8.
- MEM_BYTES, 4096, size of the addressable BRAM window in bytes, starting at 0.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- AwAddr_DI  in  ADDR_BITW  write address.
- AwValid_SI  in  1 / AwReady_SO  out  1  write address handshake.
- WData_DI  in  DATA_BITW  write data.
- WStrb_DI  in  DATA_BITW/8  write byte strobes.
- WValid_SI  in  1 / WReady_SO  out  1  write data handshake.
- BResp_DO  out  2  write response (00 OKAY, 10 SLVERR).
- BValid_SO  out  1 / BReady_SI  in  1  write response handshake.
- ArAddr_DI  in  ADDR_BITW  read address.
- ArValid_SI  in  1 / ArReady_SO  out  1  read address handshake.
- RData_DO  out  DATA_BITW  read data.
- RResp_DO  out  2  read response.
- RValid_SO  out  1 / RReady_SI  in  1  read data handshake.
- BramClk_CO  out  1  equals Clk_CI.
- BramRst_RO  out  1  equals Rst_RI.
- BramEn_SO  out  1  BRAM enable.
- BramWrEn_SO  out  DATA_BITW/8  byte write enables.
- BramAddr_SO  out  ADDR_BITW  byte address, word-aligned.
- BramWr_DO  out  DATA_BITW  write data.
- BramRd_DI  in  DATA_BITW  read data, valid the cycle after an enabled read.

Behaviour:
- Reset (synchronous, checked every cycle, overrides everything):
  - State returns to IDLE; AW/W buffer flags cleared; write priority flag set to 1.
  - All valid/ready outputs, BramEn_SO, BramWrEn_SO, BResp_DO, RResp_DO, RData_DO, BramAddr_SO and BramWr_DO are 0.
  - Any in-flight transaction is dropped with no response.
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_CAPT, RD_RESP.
- AW and W buffers are independent registers, each with a full flag.
  - AwReady_SO = IDLE and AW buffer empty. WReady_SO = IDLE and W buffer empty.
  - AW and W may handshake in the same cycle or in either order, any number of cycles apart.
- Write start: in IDLE, a write is complete when both buffers are full, or fill in the current cycle. The next state is WR_ISSUE.
- ArReady_SO = IDLE and not (write complete and priority flag = 1). A handshaked AR goes to RD_ISSUE.
- Arbitration: the priority flag toggles only when a complete write and ArValid_SI coincide in IDLE. Repeated conflicts therefore alternate write, read, write, and so on. Without a conflict, whichever request is present is served.
- WR_ISSUE, one cycle:
  - In range (address < MEM_BYTES): BramEn_SO=1, BramWrEn_SO=strobes, BramAddr_SO=address with low log2(DATA_BITW/8) bits cleared, BramWr_DO=data.
  - Out of range: no BRAM activity.
  - Clear both buffers. Next state WR_RESP.
- WR_RESP: BValid_SO=1; BResp_DO is OKAY, or SLVERR if out of range. Hold until BReady_SI, then go to IDLE.
- RD_ISSUE, one cycle: BramEn_SO=1 (only if in range), BramWrEn_SO=0, aligned address.
- RD_CAPT: register BramRd_DI into RData_DO. Out of range gives 0.
- RD_RESP: RValid_SO=1; RResp_DO is OKAY or SLVERR. RData_DO is held stable until RReady_SI, then go to IDLE.
- Latency: write handshake (later of AW/W) at T → BRAM write at T+1 → BValid at T+2. Read handshake at T → BramEn at T+1 → RValid at T+3.
- Throughput: at most one transaction per 3 (write) or 4 (read) cycles with ready responses.
- BramEn_SO and BramWrEn_SO are 0 in all states other than the issue states.
- No new AW, W or AR is accepted while a response is pending.

Test Plan:
- AW 0x10 and W 0xDEADBEEF with strobe 0xF in the same cycle T → at T+1 BramEn=1, WrEn=0xF, Addr=0x10, Wr=0xDEADBEEF; at T+2 BValid=1 with OKAY.
- W handshakes 3 cycles before AW 0x20 → WReady=0 while the W buffer is held; BRAM write occurs the cycle after AW; exactly one write.
- Read 0x10 with the BRAM model returning 0xDEADBEEF; RReady low for 5 cycles → RValid at T+3; RData stays 0xDEADBEEF; ArReady=0 until RReady is asserted.
- AW 0x13 with strobe 0x4 → BramAddr=0x10, WrEn=0x4. AW 0x1000 (= MEM_BYTES) → no BramEn, BResp=SLVERR. AR 0x1000 → RData=0, RResp=SLVERR.
- Complete write and ArValid held together for 4 transactions → grant order write, read, write, read.
- Assert Rst_RI during RD_RESP and during WR_ISSUE → next cycle all outputs 0 and ArReady/AwReady/WReady high in IDLE; no stale response afterwards.
